// File: rtl/shift_latch_rx.sv
// rtl/shift_latch_rx.sv - receive end of a multi-lane shift/latch (74HC595-style) serial link
//
// Rebuilds each frame the way a 595 chain would and presents it on a valid/ready handshake.
// Ports:
//   clk_i           system clock
//   rst_n_i         asynchronous active-low reset
//   port_i          LANES serial data lines (async to clk_i)
//   shift_i         shift strobe, rising edge samples port_i (async)
//   latch_i         latch strobe, rising edge ends the frame (async)
//   enable_i        0 = ignore the link and drop any partial frame
//   frame_data_o    lane l at [l*DEPTH +: DEPTH], first-shifted bit at the MSB
//   frame_valid_o   a frame is held until frame_ready_i
//   frame_ready_i   consumer takes the frame when valid && ready
//   len_err_o       bit count of the held frame != DEPTH (qualified by frame_valid_o)
//   overrun_o       sticky: a latch arrived while the previous frame was unaccepted
//   overrun_clr_i   synchronous clear of overrun_o
module shift_latch_rx #(
  parameter int LANES       = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [LANES-1:0]       port_i,
  input  logic                   shift_i,
  input  logic                   latch_i,
  input  logic                   enable_i,
  output logic [LANES*DEPTH-1:0] frame_data_o,
  output logic                   frame_valid_o,
  input  logic                   frame_ready_i,
  output logic                   len_err_o,
  output logic                   overrun_o,
  input  logic                   overrun_clr_i
);

  localparam int CW = $clog2(DEPTH + 2);
  localparam int AW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {ARM, DIS, IDLE, RECV} state_t;

  // Data and both strobes share one chain so a sampled bit stays aligned with its strobe.
  logic [SYNC_STAGES-1:0][LANES+1:0] sync_q;
  logic [LANES-1:0]       port_s;
  logic                   shift_s;
  logic                   latch_s;

  logic                   shift_p_q, latch_p_q;
  logic                   shift_e_q, latch_e_q;
  logic [LANES-1:0]       port_e_q;
  logic [LANES*DEPTH-1:0] sr_q;
  logic [CW-1:0]          cnt_q;
  logic [AW-1:0]          arm_q;
  state_t                 state_q;
  logic [LANES*DEPTH-1:0] frame_data_q;
  logic                   frame_valid_q, len_err_q, overrun_q;

  logic [LANES*DEPTH-1:0] sr_shift, sr_d;
  logic [CW-1:0]          cnt_inc, cnt_after;
  logic                   active, take_shift, take_latch, accept, drop;

  assign port_s  = sync_q[SYNC_STAGES-1][LANES-1:0];
  assign shift_s = sync_q[SYNC_STAGES-1][LANES];
  assign latch_s = sync_q[SYNC_STAGES-1][LANES+1];

  always_comb begin
    sr_shift = sr_q;
    for (int l = 0; l < LANES; l++) begin
      sr_shift[l*DEPTH +: DEPTH] = {sr_q[l*DEPTH +: DEPTH-1], port_e_q[l]};
    end
    cnt_inc    = (cnt_q == CW'(DEPTH + 1)) ? cnt_q : cnt_q + CW'(1);
    active     = ((state_q == IDLE) || (state_q == RECV)) && enable_i;
    take_shift = active && shift_e_q;
    take_latch = active && latch_e_q;
    // A shift landing with the latch is applied first, so the frame includes that bit.
    sr_d       = take_shift ? sr_shift : sr_q;
    cnt_after  = take_shift ? cnt_inc : cnt_q;
    accept     = take_latch && (!frame_valid_q || frame_ready_i);
    drop       = take_latch && !accept;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q        <= '0;
      shift_p_q     <= 1'b0;
      latch_p_q     <= 1'b0;
      shift_e_q     <= 1'b0;
      latch_e_q     <= 1'b0;
      port_e_q      <= '0;
      sr_q          <= '0;
      cnt_q         <= '0;
      arm_q         <= '0;
      state_q       <= ARM;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      len_err_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync_q[0] <= {latch_i, shift_i, port_i};
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      shift_p_q <= shift_s;
      latch_p_q <= latch_s;
      // Edges are masked while arming so strobes held high across reset release never count.
      shift_e_q <= shift_s && !shift_p_q && (state_q != ARM);
      latch_e_q <= latch_s && !latch_p_q && (state_q != ARM);
      port_e_q  <= port_s;
      sr_q      <= sr_d;

      if (accept) begin
        frame_data_q  <= sr_d;
        len_err_q     <= (cnt_after != CW'(DEPTH));
        frame_valid_q <= 1'b1;
      end else if (frame_valid_q && frame_ready_i) begin
        frame_valid_q <= 1'b0;
      end

      // A fresh overrun wins over a same-cycle clear.
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        ARM: begin
          cnt_q <= '0;
          if (arm_q == AW'(SYNC_STAGES)) begin
            state_q <= enable_i ? IDLE : DIS;
          end else begin
            arm_q <= arm_q + AW'(1);
          end
        end
        DIS: begin
          cnt_q <= '0;
          if (enable_i) state_q <= IDLE;
        end
        default: begin
          if (!enable_i) begin
            cnt_q   <= '0;
            state_q <= DIS;
          end else if (take_latch) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (take_shift) begin
            cnt_q   <= cnt_inc;
            state_q <= RECV;
          end
        end
      endcase
    end
  end

  assign frame_data_o  = frame_data_q;
  assign frame_valid_o = frame_valid_q;
  assign len_err_o     = len_err_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_shift_latch_rx.sv
// tb/tb_shift_latch_rx.sv - directed self-checking bench for shift_latch_rx
module tb_shift_latch_rx;

  localparam int LANES = 8;
  localparam int DEPTH = 16;
  localparam int SS    = 2;

  localparam logic [127:0] F1 = {16'h0001, 16'h7E81, 16'h3C3C, 16'hFFFF,
                                 16'h0000, 16'h1234, 16'h5A5A, 16'hA5C3};
  localparam logic [127:0] F2 = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
  localparam logic [127:0] F3 = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_1234;
  localparam logic [127:0] FA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] FB = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam logic [127:0] FC = 128'hC001_C002_C003_C004_C005_C006_C007_C008;
  localparam logic [127:0] FD = 128'h8000_4000_2000_1000_0800_0400_0200_0101;
  localparam logic [127:0] FE = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] FG = 128'h6A6A_0F0F_F0F0_3333_CCCC_5555_AAAA_9249;
  localparam logic [127:0] FH = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
  localparam logic [127:0] FJ = 128'h0246_8ACE_1357_9BDF_FEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         rst_n, shift, latch, enable, frame_ready, overrun_clr;
  logic [7:0]   port;
  logic [127:0] frame_data;
  logic         frame_valid, len_err, overrun;
  logic [127:0] sr_m;
  int           total = 0;
  int           bad   = 0;
  int           n;

  always #5 clk = ~clk;

  shift_latch_rx #(.LANES(LANES), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .port_i        (port),
    .shift_i       (shift),
    .latch_i       (latch),
    .enable_i      (enable),
    .frame_data_o  (frame_data),
    .frame_valid_o (frame_valid),
    .frame_ready_i (frame_ready),
    .len_err_o     (len_err),
    .overrun_o     (overrun),
    .overrun_clr_i (overrun_clr)
  );

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] col(input logic [127:0] f, input int i);
    logic [7:0] r;
    for (int l = 0; l < LANES; l++) r[l] = f[l*DEPTH + i];
    return r;
  endfunction

  task automatic model_shift(input logic [7:0] p);
    for (int l = 0; l < LANES; l++) sr_m[l*DEPTH +: DEPTH] = {sr_m[l*DEPTH +: DEPTH-1], p[l]};
  endtask

  task automatic shift_one(input logic [7:0] p);
    port = p;
    tick(3);
    shift = 1'b1;
    model_shift(p);
    tick(3);
    shift = 1'b0;
    tick(2);
  endtask

  task automatic send_bits(input logic [127:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) shift_one(col(f, i));
  endtask

  task automatic do_latch();
    latch = 1'b1;
    tick(3);
    latch = 1'b0;
    tick(3);
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; shift = 1'b0; latch = 1'b0; enable = 1'b1;
    frame_ready = 1'b0; overrun_clr = 1'b0; port = '0; sr_m = '0;
    tick(3);
    check("rst_valid", frame_valid, 0);
    check("rst_len_err", len_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_data", frame_data, 0);
    rst_n = 1'b1;
    tick(10);

    // full frame and latch-to-valid latency
    send_bits(F1, 15, 0);
    latch = 1'b1;
    n = 0;
    while (!frame_valid && n < 20) begin
      tick(1);
      n++;
    end
    check("t1_latency_edges", n, SS + 2);
    latch = 1'b0;
    tick(3);
    check("t1_valid", frame_valid, 1);
    check("t1_data", frame_data, F1);
    check("t1_lane0", frame_data[15:0], 16'hA5C3);
    check("t1_lane7", frame_data[127:112], 16'h0001);
    check("t1_len_err", len_err, 0);
    consume();
    check("t1_valid_fall", frame_valid, 0);

    // latch with no new bits repeats the shift register
    do_latch();
    check("idle_latch_data", frame_data, F1);
    check("idle_latch_len_err", len_err, 1);
    consume();

    // short and long frames
    send_bits(F2, 14, 0);
    do_latch();
    check("t2_short_data", frame_data, sr_m);
    check("t2_short_len_err", len_err, 1);
    consume();
    for (int i = 0; i < 4; i++) shift_one(8'hFF);
    send_bits(F3, 15, 0);
    do_latch();
    check("t2_long_data", frame_data, F3);
    check("t2_long_lane0", frame_data[15:0], 16'h1234);
    check("t2_long_len_err", len_err, 1);
    consume();

    // overrun, clear, and ready coinciding with a new latch
    send_bits(FA, 15, 0);
    do_latch();
    check("t3_a_data", frame_data, FA);
    check("t3_a_overrun", overrun, 0);
    send_bits(FB, 15, 0);
    do_latch();
    check("t3_b_overrun", overrun, 1);
    check("t3_b_kept", frame_data, FA);
    check("t3_b_valid", frame_valid, 1);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("t3_ovr_clr", overrun, 0);
    send_bits(FC, 15, 0);
    latch = 1'b1;
    tick(3);
    check("t3_c_pre_data", frame_data, FA);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    check("t3_c_valid", frame_valid, 1);
    check("t3_c_data", frame_data, FC);
    check("t3_c_overrun", overrun, 0);
    latch = 1'b0;
    tick(3);
    check("t3_c_hold", frame_valid, 1);
    consume();

    // shift and latch rising together
    send_bits(FD, 15, 1);
    port = col(FD, 0);
    tick(3);
    shift = 1'b1;
    latch = 1'b1;
    model_shift(col(FD, 0));
    tick(3);
    shift = 1'b0;
    latch = 1'b0;
    tick(3);
    check("t4_valid", frame_valid, 1);
    check("t4_data", frame_data, FD);
    check("t4_len_err", len_err, 0);
    consume();

    // reset mid-frame with strobes held high through release
    send_bits(FE, 15, 8);
    shift = 1'b1;
    latch = 1'b1;
    rst_n = 1'b0;
    sr_m  = '0;
    tick(2);
    check("t5_in_reset_data", frame_data, 0);
    tick(1);
    rst_n = 1'b1;
    tick(8);
    check("t5_no_edge_valid", frame_valid, 0);
    check("t5_no_edge_overrun", overrun, 0);
    shift = 1'b0;
    latch = 1'b0;
    tick(3);
    check("t5_low_valid", frame_valid, 0);
    send_bits(FG, 15, 0);
    do_latch();
    check("t5_data", frame_data, FG);
    check("t5_len_err", len_err, 0);
    consume();

    // disable drops a partial frame and ignores the link
    send_bits(FH, 15, 11);
    enable = 1'b0;
    tick(2);
    do_latch();
    check("t6_dis_latch", frame_valid, 0);
    enable = 1'b1;
    tick(4);
    send_bits(FJ, 15, 0);
    do_latch();
    check("t6_data", frame_data, FJ);
    check("t6_len_err", len_err, 0);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
